mem_access_unit: RTL and testbench

//  Load/store front-end placed directly upstream of data_memory in the MEM stage.
//  - Takes byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) from the EX/MEM register.
//  - Drives the word-addressed, 1-cycle-registered-read data memory.
//  - Sign/zero-extends load data.
//  - Builds sub-word stores by read-modify-write, because the memory has no byte enables.
//  - Raises stall (req_ready=0) while an access is in flight.

---
 rtl/mem_access_unit_pkg.sv | 54 +++++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM encodings, request payload and error decode for the load/store front-end.
package mem_access_unit_pkg;

   localparam int unsigned DEPTH_WORDS = 64;
   localparam int unsigned IDX_W       = 6;
   localparam int unsigned DATA_W      = 32;

   // RV32I load/store funct3 codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ERR      = 3'd1;
   localparam logic [2:0] ST_LD_ISSUE = 3'd2;
   localparam logic [2:0] ST_LD_DATA  = 3'd3;
   localparam logic [2:0] ST_ST_WRITE = 3'd4;
   localparam logic [2:0] ST_RMW_RD   = 3'd5;
   localparam logic [2:0] ST_RMW_WR   = 3'd6;

   typedef struct packed {
      logic              is_store;
      logic [2:0]        funct3;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic range_err;
      logic misalign_err;
   } req_err_t;

   // Range beats misalignment; undefined funct3 and unsigned stores report as misaligned.
   function automatic req_err_t decode_err(input logic is_store, input logic [2:0] funct3,
                                           input logic [DATA_W-1:0] addr);
      req_err_t e;
      logic     bad;
      e.range_err = (addr[DATA_W-1:IDX_W+2] != '0);
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_BU:   bad = is_store;
         F3_H:    bad = addr[0];
         F3_HU:   bad = is_store | addr[0];
         F3_W:    bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      e.misalign_err = ~e.range_err & bad;
      return e;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (purely combinational).
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] rword,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] st_data
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   // Pick the addressed byte/half of the little-endian memory word and extend it
   always_comb begin
      case (lane)
         2'd0:    sel_b = rword[7:0];
         2'd1:    sel_b = rword[15:8];
         2'd2:    sel_b = rword[23:16];
         default: sel_b = rword[31:24];
      endcase
      sel_h = lane[1] ? rword[31:16] : rword[15:0];
      case (funct3)
         F3_B:    ld_data = {{24{sel_b[7]}}, sel_b};
         F3_BU:   ld_data = {24'h0, sel_b};
         F3_H:    ld_data = {{16{sel_h[15]}}, sel_h};
         F3_HU:   ld_data = {16'h0, sel_h};
         default: ld_data = rword;
      endcase
   end

   // Replace the addressed byte/half of the old word with the low store data
   always_comb begin
      st_data = rword;
      case (funct3)
         F3_B: begin
            case (lane)
               2'd0:    st_data[7:0]   = wdata[7:0];
               2'd1:    st_data[15:8]  = wdata[7:0];
               2'd2:    st_data[23:16] = wdata[7:0];
               default: st_data[31:24] = wdata[7:0];
            endcase
         end
         F3_H: begin
            if (lane[1]) st_data[31:16] = wdata[15:0];
            else         st_data[15:0]  = wdata[15:0];
         end
         default: st_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end for a word-addressed memory without byte enables.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign_err,
   output logic        range_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   mem_req_t    req_in;
   mem_req_t    req_q;
   req_err_t    err_in;
   req_err_t    err_q;
   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [31:0] ld_data;
   logic [31:0] st_data;

   assign req_in = '{is_store: req_is_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
   assign err_in = decode_err(req_in.is_store, req_in.funct3, req_in.addr);
   assign err_q  = decode_err(req_q.is_store, req_q.funct3, req_q.addr);

   mem_lane_align u_lane (
      .funct3  (req_q.funct3),
      .lane    (req_q.addr[1:0]),
      .rword   (mem_rdata),
      .wdata   (req_q.wdata),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Request latch, loaded only on acceptance in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              req_q <= '0;
      else if (state == ST_IDLE && req_valid) req_q <= req_in;
   end

   // Next-state and output decode from registered state and latched request
   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      misalign_err = 1'b0;
      range_err    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_wdata    = '0;
      mem_addr     = (state == ST_IDLE) ? '0 : 32'(req_q.addr[IDX_W+1:2]);
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (err_in.range_err || err_in.misalign_err) state_nxt = ST_ERR;
               else if (!req_is_store)                     state_nxt = ST_LD_ISSUE;
               else if (req_funct3 == F3_W)                state_nxt = ST_ST_WRITE;
               else                                        state_nxt = ST_RMW_RD;
            end
         end
         ST_ERR: begin
            resp_valid   = 1'b1;
            range_err    = err_q.range_err;
            misalign_err = err_q.misalign_err;
            state_nxt    = ST_IDLE;
         end
         ST_LD_ISSUE: begin
            mem_read  = 1'b1;
            state_nxt = ST_LD_DATA;
         end
         ST_LD_DATA: begin
            resp_valid = 1'b1;
            resp_rdata = ld_data;
            state_nxt  = ST_IDLE;
         end
         ST_ST_WRITE: begin
            mem_write  = 1'b1;
            mem_wdata  = req_q.wdata;
            resp_valid = 1'b1;
            state_nxt  = ST_IDLE;
         end
         ST_RMW_RD: begin
            mem_read  = 1'b1;
            state_nxt = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            mem_write  = 1'b1;
            mem_wdata  = st_data;
            resp_valid = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit paired with a 1-cycle registered-read word memory.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign_err;
   logic        range_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .misalign_err(misalign_err), .range_err(range_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Word memory with registered read and a bench-only preload port
   logic [31:0] dmem [64];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_addr;
   logic [31:0] pre_data;
   always @(posedge clk) begin
      if (pre_we)         dmem[pre_addr] <= pre_data;
      else if (mem_write) dmem[mem_addr[5:0]] <= mem_wdata;
      if (mem_read)       mem_rdata <= dmem[mem_addr[5:0]];
   end

   // Reference model: byte-addressed memory image
   logic [7:0] mbytes [256];

   task automatic preload(input int w, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = 6'(w); pre_data = d;
      for (int b = 0; b < 4; b++) mbytes[w*4+b] = d[8*b +: 8];
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Architectural outcome of one access; stores update the image
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rng,
                        output logic mis, output int lat, output int nrd, output int nwr);
      int size;
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      rng = (addr >= 32'(DEPTH_WORDS*4));
      mis = 1'b0;
      if (!rng) begin
         if (size == 0 || (st && f3[2])) mis = 1'b1;
         else if ((addr % size) != 0)    mis = 1'b1;
      end
      rd = '0; lat = 1; nrd = 0; nwr = 0;
      if (!rng && !mis) begin
         if (!st) begin
            v = '0;
            for (int b = 0; b < size; b++) v = v | (32'(mbytes[addr+b]) << (8*b));
            if ((f3 == 3'd0 || f3 == 3'd1) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v; lat = 2; nrd = 1;
         end else begin
            for (int b = 0; b < size; b++) mbytes[addr+b] = wd[8*b +: 8];
            lat = (size == 4) ? 1 : 2;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
         end
      end
   endtask

   // Issue one request from IDLE and observe it until resp_valid (bounded)
   task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic rng, output logic mis, output int nrd, output int nwr,
                          output int rdc, output int wrc, output int busy_bad);
      lat = 0; rd = '0; rng = 1'b0; mis = 1'b0; nrd = 0; nwr = 0; rdc = 0; wrc = 0; busy_bad = 0;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) busy_bad++;
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (mem_read === 1'b1)  begin nrd++; if (rdc == 0) rdc = c; end
         if (mem_write === 1'b1) begin nwr++; if (wrc == 0) wrc = c; end
         if (resp_valid === 1'b1) begin
            lat = c; rd = resp_rdata; rng = range_err; mis = misalign_err;
            break;
         end
         if (req_ready !== 1'b0) busy_bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
      checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {mem_read, mem_write}); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if ({resp_rdata, range_err, misalign_err} !== 34'h0) begin errors++; $display("FAIL reset_resp got %h exp 0", {resp_rdata, range_err, misalign_err}); end
      rst = 1'b0;
      for (int w = 0; w < 64; w++) preload(w, $urandom);
      preload(5, 32'h8899_AABB);
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [4]   = '{3'd0, 3'd4, 3'd1, 3'd2};
      logic [31:0] ad [4]   = '{32'h15, 32'h15, 32'h16, 32'h14};
      logic [31:0] ex [4]   = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h8899_AABB};
      int lat, nrd, nwr, rdc, wrc, bb, elat, enrd, enwr;
      logic [31:0] rd, erd;
      logic rng, mis, erng, emis;
      for (int i = 0; i < 4; i++) begin
         model(1'b0, f3[i], ad[i], 32'h0, erd, erng, emis, elat, enrd, enwr);
         run_req(1'b0, f3[i], ad[i], 32'h0, lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
         checks++; if (lat !== 2) begin errors++; $display("FAIL load%0d_latency got %0d exp 2", i, lat); end
         checks++; if (rd !== ex[i]) begin errors++; $display("FAIL load%0d_rdata got %h exp %h", i, rd, ex[i]); end
         checks++; if ({rng, mis} !== 2'b00) begin errors++; $display("FAIL load%0d_err got %b exp 00", i, {rng, mis}); end
         checks++; if (nrd !== 1 || nwr !== 0 || rdc !== 1) begin errors++; $display("FAIL load%0d_strobes got rd%0d@%0d wr%0d exp rd1@1 wr0", i, nrd, rdc, nwr); end
      end
   endtask

   task automatic test_stores();
      logic        st [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3 [6] = '{3'd0, 3'd2, 3'd1, 3'd5, 3'd2, 3'd2};
      logic [31:0] ad [6] = '{32'h17, 32'h14, 32'h14, 32'h14, 32'h00, 32'h00};
      logic [31:0] wd [6] = '{32'h12, 32'h0, 32'hCAFE, 32'h0, 32'hDEAD_BEEF, 32'h0};
      logic [31:0] ex [6] = '{32'h0, 32'h1299_AABB, 32'h0, 32'h0000_CAFE, 32'h0, 32'hDEAD_BEEF};
      int          el [6] = '{2, 2, 2, 2, 1, 2};
      int          er [6] = '{1, 1, 1, 1, 0, 1};
      int          ew [6] = '{2, 0, 2, 0, 1, 0};
      int lat, nrd, nwr, rdc, wrc, bb, elat, enrd, enwr;
      logic [31:0] rd, erd;
      logic rng, mis, erng, emis;
      for (int i = 0; i < 6; i++) begin
         model(st[i], f3[i], ad[i], wd[i], erd, erng, emis, elat, enrd, enwr);
         run_req(st[i], f3[i], ad[i], wd[i], lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
         checks++; if (lat !== el[i]) begin errors++; $display("FAIL st%0d_latency got %0d exp %0d", i, lat, el[i]); end
         checks++; if (rd !== ex[i]) begin errors++; $display("FAIL st%0d_rdata got %h exp %h", i, rd, ex[i]); end
         checks++; if (rdc !== er[i] || wrc !== ew[i]) begin errors++; $display("FAIL st%0d_strobe_cycle got rd@%0d wr@%0d exp rd@%0d wr@%0d", i, rdc, wrc, er[i], ew[i]); end
         checks++; if (bb !== 0) begin errors++; $display("FAIL st%0d_ready got %0d bad cycles exp 0", i, bb); end
      end
   endtask

   task automatic test_errors();
      logic        st [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3 [6] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd1};
      logic [31:0] ad [6] = '{32'h13, 32'h100, 32'hFC, 32'h0, 32'h8, 32'h101};
      logic        xr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        xm [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat, nrd, nwr, rdc, wrc, bb, elat, enrd, enwr;
      logic [31:0] rd, erd;
      logic rng, mis, erng, emis;
      for (int i = 0; i < 6; i++) begin
         model(st[i], f3[i], ad[i], 32'h5A5A_5A5A, erd, erng, emis, elat, enrd, enwr);
         run_req(st[i], f3[i], ad[i], 32'h5A5A_5A5A, lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
         checks++; if ({rng, mis} !== {xr[i], xm[i]}) begin errors++; $display("FAIL err%0d_flags got %b exp %b", i, {rng, mis}, {xr[i], xm[i]}); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL err%0d_latency got %0d exp %0d", i, lat, elat); end
         checks++; if (rd !== erd) begin errors++; $display("FAIL err%0d_rdata got %h exp %h", i, rd, erd); end
         checks++; if (nrd !== enrd || nwr !== enwr) begin errors++; $display("FAIL err%0d_strobes got rd%0d wr%0d exp rd%0d wr%0d", i, nrd, nwr, enrd, enwr); end
      end
   endtask

   task automatic test_reset_mid();
      int lat, nrd, nwr, rdc, wrc, bb, elat, enrd, enwr;
      logic [31:0] rd, erd;
      logic rng, mis, erng, emis;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = 32'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rstmid_rmw_read got %b exp 1", mem_read); end
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got ready%b resp%b exp ready1 resp0", req_ready, resp_valid); end
      @(posedge clk); #1;
      checks++; if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_write got wr%b resp%b exp 0 0", mem_write, resp_valid); end
      rst = 1'b0;
      model(1'b0, 3'd2, 32'h14, 32'h0, erd, erng, emis, elat, enrd, enwr);
      run_req(1'b0, 3'd2, 32'h14, 32'h0, lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
      checks++; if (rd !== erd) begin errors++; $display("FAIL rstmid_word_kept got %h exp %h", rd, erd); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3 [3];
      logic [31:0] ad [3];
      logic [31:0] erd [3];
      logic [31:0] got [3];
      logic        erng, emis, rdy_prev;
      int          elat, enrd, enwr, k, nresp, cyc, last;
      f3[0] = 3'd2; ad[0] = 32'($urandom_range(0, 63)) << 2;
      f3[1] = 3'd4; ad[1] = 32'($urandom_range(0, 255));
      f3[2] = 3'd1; ad[2] = 32'($urandom_range(0, 127)) << 1;
      for (int i = 0; i < 3; i++) model(1'b0, f3[i], ad[i], 32'h0, erd[i], erng, emis, elat, enrd, enwr);
      for (int i = 0; i < 3; i++) got[i] = '0;
      k = 0; nresp = 0; cyc = 0; last = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = f3[0]; req_addr = ad[0];
      rdy_prev = req_ready;
      while (nresp < 3 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (rdy_prev && k < 3) begin
            k++;
            if (k < 3) begin req_funct3 = f3[k]; req_addr = ad[k]; end
            else req_valid = 1'b0;
         end
         if (resp_valid === 1'b1) begin
            if (nresp < 3) got[nresp] = resp_rdata;
            nresp++; last = cyc;
         end
         rdy_prev = (req_ready === 1'b1) && req_valid;
      end
      req_valid = 1'b0;
      checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_resp_count got %0d exp 3", nresp); end
      checks++; if (last !== 8) begin errors++; $display("FAIL b2b_last_resp_cycle got %0d exp 8", last); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got[i] !== erd[i]) begin errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, got[i], erd[i]); end
      end
   endtask

   task automatic test_random();
      logic        st;
      logic [2:0]  f3;
      logic [31:0] ad, wd, rd, erd;
      logic        rng, mis, erng, emis;
      int lat, nrd, nwr, rdc, wrc, bb, elat, enrd, enwr;
      for (int i = 0; i < 60; i++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
         end
         case ($urandom_range(0, 9))
            0:       ad = $urandom;
            1:       ad = 32'h100 + 32'($urandom_range(0, 15));
            2, 3, 4: ad = 32'($urandom_range(0, 63)) << 2;
            default: ad = 32'($urandom_range(0, 255));
         endcase
         wd = $urandom;
         model(st, f3, ad, wd, erd, erng, emis, elat, enrd, enwr);
         run_req(st, f3, ad, wd, lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
         checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency st%b f3=%0d a=%h got %0d exp %0d", i, st, f3, ad, lat, elat); end
         checks++; if (rd !== erd) begin errors++; $display("FAIL rnd%0d_rdata st%b f3=%0d a=%h got %h exp %h", i, st, f3, ad, rd, erd); end
         checks++; if ({rng, mis} !== {erng, emis}) begin errors++; $display("FAIL rnd%0d_flags got %b exp %b", i, {rng, mis}, {erng, emis}); end
         checks++; if (nrd !== enrd || nwr !== enwr) begin errors++; $display("FAIL rnd%0d_strobes got rd%0d wr%0d exp rd%0d wr%0d", i, nrd, nwr, enrd, enwr); end
         checks++; if (bb !== 0) begin errors++; $display("FAIL rnd%0d_ready got %0d bad cycles exp 0", i, bb); end
      end
      // Final sweep of every word through loads confirms stored contents
      for (int w = 0; w < 64; w++) begin
         model(1'b0, 3'd2, 32'(w*4), 32'h0, erd, erng, emis, elat, enrd, enwr);
         run_req(1'b0, 3'd2, 32'(w*4), 32'h0, lat, rd, rng, mis, nrd, nwr, rdc, wrc, bb);
         checks++; if (rd !== erd) begin errors++; $display("FAIL sweep_word%0d got %h exp %h", w, rd, erd); end
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
